// File: rtl/hazard_pkg.sv
// Shared types and defaults for the stall/flush hazard unit.
package hazard_pkg;

    // Default register-index width and mul/div execute latency.
    localparam int REG_W      = 5;
    localparam int MD_LAT_DEF = 4;
    localparam int MD_CNT_W   = 4;

    typedef logic [REG_W-1:0] reg_idx_t;

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } hz_state_e;

endpackage

// File: rtl/hazard_md_counter.sv
// Mul/div occupancy down-counter: load, decrement, done when the count is 1.
module hazard_md_counter
    import hazard_pkg::*;
#(
    parameter int CNT_W = MD_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             done
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Load has priority; decrement saturates at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (dec && (cnt_q != '0))
            cnt_d = cnt_q - 1'b1;
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt  = cnt_q;
    assign done = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/stall_hazard_unit.sv
// Pipeline stall/flush control: load-use stall, taken-branch flush and,
// when MULDIV_STALL_EN is defined, a multicycle mul/div hold of MD_LAT cycles.
module stall_hazard_unit
    import hazard_pkg::*;
#(
    parameter int WIDTH  = REG_W,
    parameter int MD_LAT = MD_LAT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] RegS1D,
    input  logic [WIDTH-1:0] RegS2D,
    input  logic [WIDTH-1:0] WriteRegE,
    input  logic             MemReadE,
    input  logic             BranchTakenE,
    input  logic             MdStartE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic             MdBusy
);

    logic luse;

    // A load writing x0 never creates a dependency.
    assign luse = MemReadE && (WriteRegE != '0) &&
                  ((WriteRegE == RegS1D) || (WriteRegE == RegS2D));

`ifdef MULDIV_STALL_EN
    hz_state_e            state_q, state_d;
    logic                 md_load, md_dec, md_done;
    logic [MD_CNT_W-1:0]  md_cnt;

    assign md_load = (state_q == RUN) && MdStartE;
    assign md_dec  = (state_q == MD_BUSY);

    hazard_md_counter #(.CNT_W(MD_CNT_W)) u_md_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (md_load),
        .load_val (MD_CNT_W'(MD_LAT - 1)),
        .dec      (md_dec),
        .cnt      (md_cnt),
        .done     (md_done)
    );

    logic unused_md_cnt;
    assign unused_md_cnt = ^md_cnt;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst)
            state_q <= RUN;
        else
            state_q <= state_d;
    end

    // Next state: start enters busy, count of 1 leaves it; restarts while busy are dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (MdStartE) state_d = MD_BUSY;
            MD_BUSY: if (md_done)  state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Outputs: busy hold > mul/div start > branch flush > load-use stall.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushM = 1'b0;
        MdBusy = 1'b0;
        if (rst) begin
            if (state_q == MD_BUSY) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                FlushM = 1'b1;
                MdBusy = 1'b1;
            end else if (MdStartE) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                FlushM = 1'b1;
            end else if (BranchTakenE) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (luse) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end
`else
    // Without the mul/div hold the unit is purely combinational.
    logic unused_cfg;
    assign unused_cfg = clk ^ MdStartE ^ (MD_LAT == 0);

    // Outputs: branch flush beats load-use stall; reset forces everything low.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushM = 1'b0;
        MdBusy = 1'b0;
        if (rst) begin
            if (BranchTakenE) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (luse) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_stall_hazard_unit.sv
// Directed bench for stall_hazard_unit; expectations adapt to MULDIV_STALL_EN.
module tb_stall_hazard_unit;

    logic       clk;
    logic       rst;
    logic [4:0] RegS1D, RegS2D, WriteRegE;
    logic       MemReadE, BranchTakenE, MdStartE;
    logic       StallF, StallD, StallE, FlushD, FlushE, FlushM, MdBusy;

    int n_chk;
    int n_err;

`ifdef MULDIV_STALL_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    // Output vector order: {StallF,StallD,StallE,FlushD,FlushE,FlushM,MdBusy}
    localparam logic [6:0] O_NONE = 7'b0000000;
    localparam logic [6:0] O_LUSE = 7'b1100100;
    localparam logic [6:0] O_BR   = 7'b0001100;
    localparam logic [6:0] O_MDST = 7'b1110010;
    localparam logic [6:0] O_BUSY = 7'b1110011;

    stall_hazard_unit #(.WIDTH(5), .MD_LAT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .RegS1D       (RegS1D),
        .RegS2D       (RegS2D),
        .WriteRegE    (WriteRegE),
        .MemReadE     (MemReadE),
        .BranchTakenE (BranchTakenE),
        .MdStartE     (MdStartE),
        .StallF       (StallF),
        .StallD       (StallD),
        .StallE       (StallE),
        .FlushD       (FlushD),
        .FlushE       (FlushE),
        .FlushM       (FlushM),
        .MdBusy       (MdBusy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs after the falling edge, then sample the outputs.
    task automatic step(input string tag, input logic r, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [4:0] wr, input logic mr,
                        input logic br, input logic md, input logic [6:0] exp);
        @(negedge clk);
        rst          = r;
        RegS1D       = s1;
        RegS2D       = s2;
        WriteRegE    = wr;
        MemReadE     = mr;
        BranchTakenE = br;
        MdStartE     = md;
        #1;
        chk(tag, {StallF, StallD, StallE, FlushD, FlushE, FlushM, MdBusy}, exp);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst = 1'b0; RegS1D = '0; RegS2D = '0; WriteRegE = '0;
        MemReadE = 1'b0; BranchTakenE = 1'b0; MdStartE = 1'b0;

        // Reset state, and reset masking an active load-use hazard
        step("rst_idle",   1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, O_NONE);
        step("rst_luse",   1'b0, 5'd3, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0, O_NONE);
        step("run_idle",   1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, O_NONE);

        // Load-use: single bubble, then clear
        step("luse_rs2",   1'b1, 5'd3, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0, O_LUSE);
        step("luse_after", 1'b1, 5'd3, 5'd9, 5'd4, 1'b0, 1'b0, 1'b0, O_NONE);
        step("luse_rs1",   1'b1, 5'd17, 5'd2, 5'd17, 1'b1, 1'b0, 1'b0, O_LUSE);
        step("luse_x0",    1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, O_NONE);
        step("no_load",    1'b1, 5'd9, 5'd9, 5'd9, 1'b0, 1'b0, 1'b0, O_NONE);
        step("no_match",   1'b1, 5'd8, 5'd10, 5'd9, 1'b1, 1'b0, 1'b0, O_NONE);
        step("max_idx",    1'b1, 5'd1, 5'd31, 5'd31, 1'b1, 1'b0, 1'b0, O_LUSE);

        // Branch flush, alone and overriding load-use
        step("branch",     1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, O_BR);
        step("br_luse",    1'b1, 5'd9, 5'd2, 5'd9, 1'b1, 1'b1, 1'b0, O_BR);
        step("br_after",   1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, O_NONE);

        // Mul/div start with a same-cycle branch: start wins when enabled
        step("md_start",   1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, MD ? O_MDST : O_BR);
        step("md_busy3",   1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, MD ? O_BUSY : O_NONE);
        // Second start and load-use mid-busy are ignored
        step("md_busy2",   1'b1, 5'd9, 5'd9, 5'd9, 1'b1, 1'b0, 1'b1, MD ? O_BUSY : O_LUSE);
        step("md_busy1",   1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, MD ? O_BUSY : O_BR);
        step("md_done",    1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, O_NONE);
        step("md_run",     1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, O_LUSE);

        // Reset in the middle of a busy period (count 2)
        step("rm_start",   1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, MD ? O_MDST : O_NONE);
        step("rm_busy3",   1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, MD ? O_BUSY : O_NONE);
        step("rm_rst",     1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, O_NONE);
        step("rm_after",   1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, O_NONE);
        step("rm_run",     1'b1, 5'd0, 5'd7, 5'd7, 1'b1, 1'b0, 1'b0, O_LUSE);

        // Fresh start after reset gives the full latency again
        step("fs_start",   1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, MD ? O_MDST : O_NONE);
        step("fs_busy3",   1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, MD ? O_BUSY : O_NONE);
        step("fs_busy2",   1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, MD ? O_BUSY : O_NONE);
        step("fs_busy1",   1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, MD ? O_BUSY : O_NONE);
        step("fs_done",    1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, O_NONE);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/stall_hazard_unit.md
STALL_HAZARD_UNIT -- requirements
Module: stall_hazard_unit

Interface
REQ-001 Parameter WIDTH, default 5, register-index width.
REQ-002 Parameter MD_LAT, default 4, total EX-stage cycles of a mul/div op, legal range 2..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 RegS1D  input  WIDTH  rs1 index of the instruction in decode.
REQ-006 RegS2D  input  WIDTH  rs2 index of the instruction in decode.
REQ-007 WriteRegE  input  WIDTH  rd index of the instruction in execute.
REQ-008 MemReadE  input  1  instruction in execute is a load.
REQ-009 BranchTakenE  input  1  branch/jump in execute resolved taken.
REQ-010 MdStartE  input  1  mul/div entering execute this cycle; 1-cycle pulse.
REQ-011 StallF, StallD, StallE  output  1 each  hold the PC, IF/ID and ID/EX registers.
REQ-012 FlushD, FlushE, FlushM  output  1 each  bubble into IF/ID, ID/EX and EX/MEM.
REQ-013 MdBusy  output  1  multicycle op in progress.

Function
REQ-014 States: RUN, MD_BUSY; 4-bit down-counter md_cnt.
REQ-015 Load-use: luse = MemReadE & (WriteRegE != 0) & ((WriteRegE == RegS1D) | (WriteRegE == RegS2D)).
REQ-016 Index 0 never produces a hazard.
REQ-017 In RUN with luse: StallF=StallD=FlushE=1 in the same cycle, combinational, with 1 bubble only.
REQ-018 In RUN with BranchTakenE: FlushD=FlushE=1 in the same cycle; no stall.
REQ-019 In RUN, luse and BranchTakenE together: flush wins; StallF=StallD=0, FlushD=FlushE=1.
REQ-020 In RUN with MdStartE: go to MD_BUSY next edge; md_cnt <= MD_LAT-1.
REQ-021 MdStartE takes precedence over BranchTakenE in the same cycle; the branch is ignored.
REQ-022 In the MdStartE cycle itself: StallF=StallD=StallE=1, FlushM=1.
REQ-023 In MD_BUSY: StallF=StallD=StallE=FlushM=MdBusy=1.
REQ-024 In MD_BUSY: luse and BranchTakenE are ignored; md_cnt decrements each cycle.
REQ-025 In MD_BUSY at md_cnt==1: return to RUN next edge; stalls drop in the first RUN cycle.
REQ-026 Total EX occupancy of a mul/div is exactly MD_LAT cycles.
REQ-027 MdStartE during MD_BUSY is ignored; no restart, no count reload.
REQ-028 In RUN, outputs not asserted by REQ-017..022 are 0.

Reset
REQ-029 rst low at an edge: state=RUN, md_cnt=0, next cycle all outputs 0, including mid-MD_BUSY.
REQ-030 While rst is low, all outputs are forced to 0 combinationally.

Configuration
REQ-031 Macro MULDIV_STALL_EN defined: REQ-020..027 and MdBusy behaviour apply.
REQ-032 Macro MULDIV_STALL_EN absent: MdStartE ignored; no MD_BUSY state, no md_cnt.
REQ-033 Macro MULDIV_STALL_EN absent: StallE=FlushM=MdBusy=0 permanently; MD_LAT unused.

Structure
REQ-034 Package hazard_pkg holds the state enum (RUN, MD_BUSY) and the MD_LAT default.
REQ-035 Package hazard_pkg also holds typedef reg_idx_t (WIDTH-bit index).
REQ-036 Sub-module hazard_md_counter (load, decrement, done==1 flag) is instantiated under MULDIV_STALL_EN.

Verification
REQ-037 Reset: rst=0 during MD_BUSY with md_cnt=2 -> next cycle all outputs 0, state RUN.
REQ-038 Load-use: MemReadE=1, WriteRegE=9, RegS2D=9 -> StallF=StallD=FlushE=1 for 1 cycle.
REQ-039 Load-use x0: MemReadE=1, WriteRegE=0, RegS2D=0 -> all outputs 0.
REQ-040 Branch with luse: BranchTakenE=1 with luse=1 -> FlushD=FlushE=1, StallF=StallD=0.
REQ-041 Mul/div, MD_LAT=4: MdStartE pulse -> StallE=FlushM=1 for exactly 4 cycles, MdBusy for 3 cycles.
REQ-042 Mul/div busy: second MdStartE and luse mid-busy ignored; with macro off -> StallE=0 always.
